// File: rtl/branch_dispatch.sv
// Branch issue stage: accepts one branch from decode, drives the condition
// evaluator, and converts its result into a one-cycle redirect/flush.
module branch_dispatch #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_br_valid,
  output logic             o_br_ready,
  input  logic [1:0]       i_br_kind,
  input  logic [PC_W-1:0]  i_br_rs,
  input  logic [PC_W-1:0]  i_br_rt,
  input  logic [PC_W-1:0]  i_br_pc,
  input  logic [15:0]      i_br_offset,
  output logic [1:0]       o_cond_kind,
  output logic             o_cond_data,
  input  logic             i_cond_taken,
  input  logic             i_kill,
  output logic             o_stall,
  output logic             o_redirect_valid,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_taken_count
);

  localparam int unsigned OFF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EVAL    = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_kind;
  logic              r_flag;
  logic [PC_W-1:0]   r_target;
  logic              r_taken_q;
  logic [CNT_W-1:0]  r_taken_count;

  logic              w_accept;
  logic [PC_W-1:0]   w_offset_ext;
  logic [PC_W-1:0]   w_target;

  assign w_accept     = (r_state == S_IDLE) && i_br_valid && !i_kill;
  // Word offset sign-extended to PC width, target wraps modulo 2^PC_W.
  assign w_offset_ext = {{(PC_W-OFF_W){i_br_offset[OFF_W-1]}}, i_br_offset};
  assign w_target     = i_br_pc + PC_W'(4) + (w_offset_ext << 2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; kill aborts any in-flight branch
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_EVAL;
      S_EVAL:    w_state_nxt = i_kill ? S_IDLE : S_RESOLVE;
      S_RESOLVE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Captured branch, evaluator result and saturating redirect counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind        <= 2'd0;
      r_flag        <= 1'b0;
      r_target      <= '0;
      r_taken_q     <= 1'b0;
      r_taken_count <= '0;
    end else begin
      if (w_accept) begin
        r_kind   <= i_br_kind;
        r_flag   <= (i_br_rs == i_br_rt);
        r_target <= w_target;
      end
      if (r_state == S_EVAL) r_taken_q <= i_cond_taken;
      if ((r_state == S_RESOLVE) && r_taken_q && !i_kill && (r_taken_count != '1))
        r_taken_count <= r_taken_count + CNT_W'(1);
    end
  end

  // Output decode
  always_comb begin
    o_br_ready       = 1'b0;
    o_stall          = 1'b0;
    o_cond_kind      = 2'd3;
    o_cond_data      = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    case (r_state)
      S_IDLE: o_br_ready = 1'b1;
      S_EVAL: begin
        o_stall     = 1'b1;
        o_cond_kind = r_kind;
        o_cond_data = r_flag;
      end
      S_RESOLVE: begin
        o_stall          = 1'b1;
        o_redirect_valid = r_taken_q && !i_kill;
        o_redirect_pc    = r_taken_q ? r_target : '0;
      end
      default: o_br_ready = 1'b0;
    endcase
  end

  assign o_flush       = o_redirect_valid;
  assign o_taken_count = r_taken_count;

endmodule
